// File: rtl/dec_chan_sched.sv
// dec_chan_sched: per-channel codeword FIFOs feeding one shared ADPCM decoder core.
// Each fs pulse issues exactly one decode per channel, 0..NCH-1. Optional watchdog: DEC_TIMEOUT_EN.
module dec_chan_fifo #(
  parameter int CW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] head,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty.
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign head  = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
endmodule

module dec_chan_sched #(
  parameter int NCH     = 4,
  parameter int CW      = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [$clog2(NCH)-1:0] in_chan,
  input  logic [CW-1:0]          in_code,
  input  logic                   fs,
  output logic                   dec_start,
  output logic [$clog2(NCH)-1:0] dec_chan,
  output logic [CW-1:0]          dec_code,
  input  logic                   dec_done,
  output logic                   busy,
  output logic [NCH-1:0]         underrun,
  output logic                   frame_ovr,
  output logic                   bad_chan,
`ifdef DEC_TIMEOUT_EN
  output logic                   dec_timeout,
`endif
  input  logic                   clr_status
);
  localparam int CHW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CW-1:0]  code_q, code_d;
  logic [NCH-1:0] underrun_q, underrun_d;
  logic           ovr_q, ovr_d, bad_q, bad_d;

  logic [NCH-1:0]         push, pop, empty, full;
  logic [NCH-1:0][CW-1:0] head;
  logic                   in_hit, sel_full, sel_pop, cur_empty, issue, slot_done;
  logic [CW-1:0]          cur_head, cur_code;

  assign issue = (state_q == ISSUE);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign push[i] = in_valid && in_ready && (in_chan == CHW'(i));
    assign pop[i]  = issue && (ch_q == CHW'(i)) && !empty[i];
    dec_chan_fifo #(.CW(CW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_code),
      .head  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  // A full FIFO still accepts when its head is popped this cycle; unknown channels always accept.
  always_comb begin
    in_hit    = 1'b0;
    sel_full  = 1'b0;
    sel_pop   = 1'b0;
    cur_empty = 1'b1;
    cur_head  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (in_chan == CHW'(i)) begin
        in_hit   = 1'b1;
        sel_full = full[i];
        sel_pop  = pop[i];
      end
      if (ch_q == CHW'(i)) begin
        cur_empty = empty[i];
        cur_head  = head[i];
      end
    end
    in_ready = !sel_full || sel_pop;
    cur_code = cur_empty ? '0 : cur_head;
  end

`ifdef DEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d, expired;

  assign expired   = (state_q == WAIT) && !dec_done && (cnt_q == TW'(TIMEOUT - 1));
  assign slot_done = dec_done || expired;

  always_comb begin
    cnt_d = (state_q == WAIT) ? cnt_q + TW'(1) : '0;
    to_d  = clr_status ? 1'b0 : to_q;
    if (expired) to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign dec_timeout = to_q;
`else
  assign slot_done = dec_done;
`endif

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    code_d     = code_q;
    underrun_d = clr_status ? '0 : underrun_q;
    ovr_d      = clr_status ? 1'b0 : ovr_q;
    bad_d      = clr_status ? 1'b0 : bad_q;
    if (in_valid && !in_hit) bad_d = 1'b1;
    if (fs && (state_q != IDLE)) ovr_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (fs) begin
          ch_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Empty slot still issues the silence code so the core's adaptation keeps running.
        code_d = cur_code;
        if (cur_empty) underrun_d[ch_q] = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (slot_done) begin
          if (ch_q == CHW'(NCH - 1)) begin
            state_d = IDLE;
          end else begin
            ch_d    = ch_q + CHW'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      code_q     <= '0;
      underrun_q <= '0;
      ovr_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      code_q     <= code_d;
      underrun_q <= underrun_d;
      ovr_q      <= ovr_d;
      bad_q      <= bad_d;
    end
  end

  assign dec_start = issue;
  assign dec_chan  = ch_q;
  assign dec_code  = issue ? cur_code : code_q;
  assign busy      = (state_q != IDLE);
  assign underrun  = underrun_q;
  assign frame_ovr = ovr_q;
  assign bad_chan  = bad_q;
endmodule
